// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared store/load type codes and responder state encoding
package mem_responder_pkg;
  typedef enum logic [1:0] {DMWR_NONE = 2'd0, DMWR_SW, DMWR_SH, DMWR_SB} dmwr_e;
  typedef enum logic [2:0] {DMRE_NONE = 3'd0, DMRE_LW, DMRE_LH, DMRE_LHU, DMRE_LB, DMRE_LBU} dmre_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane steering, load extension and alignment check
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  wr,
  input  logic [2:0]  re,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rword[{addr, 3'b000} +: 8];
    h = addr[1] ? rword[31:16] : rword[15:0];
    be = wr == DMWR_SW ? 4'hf :
         wr == DMWR_SH ? (addr[1] ? 4'hc : 4'h3) :
         wr == DMWR_SB ? 4'b0001 << addr : 4'h0;
    wword = wr == DMWR_SH ? {2{wdata[15:0]}} : wr == DMWR_SB ? {4{wdata[7:0]}} : wdata;
    rdata = re == DMRE_LW  ? rword :
            re == DMRE_LH  ? {{16{h[15]}}, h} :
            re == DMRE_LHU ? {16'h0, h} :
            re == DMRE_LB  ? {{24{b[7]}}, b} :
            re == DMRE_LBU ? {24'h0, b} : 32'h0;
    misalign = ((wr == DMWR_SW || re == DMRE_LW) && addr != 2'b00) ||
               ((wr == DMWR_SH || re == DMRE_LH || re == DMRE_LHU) && addr[0]);
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word RAM behind a valid/ready port with programmable wait states
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_wr,
  input  logic [2:0]        req_re,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  state_e              state, nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   a_q;
  logic [1:0]          wr_q;
  logic [2:0]          re_q;
  logic [31:0]         wd_q;
  logic [31:0]         ram [DEPTH];
  logic [ADDR_W-3:0]   idx;
  logic [31:0]         word, wword, rdata;
  logic [3:0]          be;
  logic                misalign, err, done;
  assign idx  = a_q[ADDR_W-1:2];
  assign word = ram[idx];
  mem_lane_align u_align (
    .addr(a_q[1:0]), .wr(wr_q), .re(re_q), .wdata(wd_q), .rword(word),
    .be(be), .wword(wword), .rdata(rdata), .misalign(misalign)
  );
  always_comb begin
    req_ready = state == ST_IDLE;
    rsp_valid = state == ST_RESP;
    done      = state == ST_ACCESS && cnt == 4'd0;
    err       = (wr_q != DMWR_NONE && re_q != DMRE_NONE) || int'(idx) >= DEPTH ||
                misalign || re_q > DMRE_LBU;
    nxt = state == ST_IDLE   ? (req_valid ? ST_ACCESS : ST_IDLE) :
          state == ST_ACCESS ? (done ? ST_RESP : ST_ACCESS) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= 4'd0;
      a_q       <= '0;
      wr_q      <= 2'd0;
      re_q      <= 3'd0;
      wd_q      <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (req_ready && req_valid) begin
      cnt  <= 4'(WAIT_CYCLES - 1);
      a_q  <= req_addr;
      wr_q <= req_wr;
      re_q <= req_re;
      wd_q <= req_wdata;
    end else if (done) begin
      rsp_rdata <= err ? 32'h0 : rdata;
      rsp_err   <= err;
    end else if (state == ST_ACCESS) cnt <= cnt - 4'd1;
  // State leaves ACCESS asynchronously on reset, so an uncommitted write is dropped
  always_ff @(posedge clk)
    if (done && !err)
      for (int k = 0; k < 4; k++)
        if (be[k]) ram[idx][8*k +: 8] <= wword[8*k +: 8];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks against a byte-array reference memory
module tb_mem_responder;
  localparam int WAIT  = 2;
  localparam int DEPTH = 255;
  logic        clk = 0, rst = 0, req_valid = 0, req_ready, rsp_valid, rsp_err;
  logic [9:0]  req_addr = 0;
  logic [1:0]  req_wr = 0;
  logic [2:0]  req_re = 0;
  logic [31:0] req_wdata = 0, rsp_rdata;
  logic [7:0]  mb [1024];
  int          nchk = 0, nerr = 0;
  logic        ev [$];
  logic [31:0] dq [$];

  mem_responder #(.ADDR_W(10), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr(req_wr), .req_re(req_re), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from the type code, two's complement extension
  function automatic void model(input logic [9:0] a, input logic [1:0] w, input logic [2:0] r,
                                input logic [31:0] d, output logic e, output logic [31:0] q);
    int sz, off;
    longint v;
    off = int'(a % 4);
    sz = (w == 1 || r == 1) ? 4 : (w == 2 || r == 2 || r == 3) ? 2 : (w == 3 || r == 4 || r == 5) ? 1 : 0;
    e = (w != 0 && r != 0) || int'(a / 4) >= DEPTH || r > 5 || (sz > 1 && off % sz != 0);
    q = 0;
    if (!e && w != 0)
      for (int i = 0; i < sz; i++) mb[int'(a) + i] = d[8*i +: 8];
    if (!e && r != 0) begin
      v = 0;
      for (int i = 0; i < sz; i++) v += longint'(mb[int'(a) + i]) << (8 * i);
      if ((r == 2 || r == 4) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
      q = v[31:0];
    end
  endfunction

  task automatic xact(input logic [9:0] a, input logic [1:0] w, input logic [2:0] r,
                      input logic [31:0] d, output logic ge, output logic [31:0] gq);
    logic ee;
    logic [31:0] eq;
    int cyc;
    model(a, w, r, d, ee, eq);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_addr = a; req_wr = w; req_re = r; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 0; req_addr = 10'($urandom); req_wr = 2'($urandom);
    req_re = 3'($urandom); req_wdata = $urandom;
    check("ready_busy", 32'(req_ready), 0);
    cyc = 1;
    @(negedge clk);
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, WAIT + 1);
    check("err", 32'(rsp_err), 32'(ee));
    check("rdata", rsp_rdata, eq);
    check("ready_resp", 32'(req_ready), 0);
    ge = rsp_err;
    gq = rsp_rdata;
    @(negedge clk);
    check("strobe_1cyc", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic        ge, pe;
    logic [31:0] gq, pq, prior;
    logic [9:0]  ba [4];
    logic [1:0]  bw [4];
    logic [2:0]  br [4];
    logic [31:0] bd [4];
    int          idx, got, cyc, last, mode;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_valid", 32'(rsp_valid), 0);
    rst = 1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_valid", 32'(rsp_valid), 0);
    check("post_rst_rdata", rsp_rdata, 0);
    check("post_rst_err", 32'(rsp_err), 0);
    for (int i = 0; i < DEPTH; i++) xact(10'(i * 4), 2'd1, 3'd0, $urandom, ge, gq);
    xact(10'h010, 2'd1, 3'd0, 32'hDEADBEEF, ge, gq);
    check("sw_err", 32'(ge), 0);
    xact(10'h010, 2'd0, 3'd1, 0, ge, gq);
    check("lw_word", gq, 32'hDEADBEEF);
    xact(10'h023, 2'd3, 3'd0, 32'h80, ge, gq);
    xact(10'h023, 2'd0, 3'd4, 0, ge, gq);
    check("lb_sext", gq, 32'hFFFFFF80);
    xact(10'h023, 2'd0, 3'd5, 0, ge, gq);
    check("lbu_zext", gq, 32'h00000080);
    xact(10'h022, 2'd2, 3'd0, 32'h8001, ge, gq);
    xact(10'h022, 2'd0, 3'd2, 0, ge, gq);
    check("lh_sext", gq, 32'hFFFF8001);
    xact(10'h022, 2'd0, 3'd3, 0, ge, gq);
    check("lhu_zext", gq, 32'h00008001);
    xact(10'h020, 2'd0, 3'd3, 0, ge, gq);
    check("low_half_kept", gq, {16'h0, mb[33], mb[32]});
    xact(10'h011, 2'd1, 3'd0, 32'h11111111, ge, gq);
    check("sw_misalign_err", 32'(ge), 1);
    xact(10'h010, 2'd0, 3'd1, 0, ge, gq);
    check("sw_misalign_nowrite", gq, 32'hDEADBEEF);
    xact(10'h021, 2'd0, 3'd2, 0, ge, gq);
    check("lh_misalign_err", 32'(ge), 1);
    check("lh_misalign_rdata", gq, 0);
    xact(10'h010, 2'd1, 3'd1, 32'h5, ge, gq);
    check("wr_re_err", 32'(ge), 1);
    xact(10'h3FC, 2'd0, 3'd1, 0, ge, gq);
    check("oob_err", 32'(ge), 1);
    xact(10'h014, 2'd0, 3'd6, 0, ge, gq);
    check("bad_re_err", 32'(ge), 1);
    xact(10'h014, 2'd0, 3'd0, 32'hFFFF, ge, gq);
    check("noop_err", 32'(ge), 0);
    check("noop_rdata", gq, 0);
    // Back-to-back with req_valid held; each store is followed by a load of the same word
    for (int i = 0; i < 4; i += 2) begin
      ba[i] = 10'($urandom_range(0, DEPTH - 1) * 4); bw[i] = 2'd1; br[i] = 3'd0; bd[i] = $urandom;
      ba[i+1] = ba[i]; bw[i+1] = 2'd0; br[i+1] = 3'd1; bd[i+1] = $urandom;
    end
    @(negedge clk);
    req_valid = 1; req_addr = ba[0]; req_wr = bw[0]; req_re = br[0]; req_wdata = bd[0];
    idx = 0; got = 0; cyc = 0; last = -1;
    while (got < 4 && cyc < 200) begin
      if (rsp_valid) begin
        check("b2b_err", 32'(rsp_err), 32'(ev.pop_front()));
        check("b2b_rdata", rsp_rdata, dq.pop_front());
        got++;
      end
      if (req_ready && req_valid) begin
        if (last >= 0) check("b2b_gap", cyc - last, WAIT + 2);
        last = cyc;
        model(ba[idx], bw[idx], br[idx], bd[idx], pe, pq);
        ev.push_back(pe);
        dq.push_back(pq);
        idx++;
        @(posedge clk);
        #1;
        if (idx < 4) begin
          req_addr = ba[idx]; req_wr = bw[idx]; req_re = br[idx]; req_wdata = bd[idx];
        end else req_valid = 0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_count", got, 4);
    req_valid = 0;
    // Reset during ACCESS drops the pending store
    prior = {mb[67], mb[66], mb[65], mb[64]};
    @(negedge clk);
    req_valid = 1; req_addr = 10'h040; req_wr = 2'd1; req_re = 3'd0; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("midrst_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst = 1;
    got = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) got++;
    end
    check("midrst_no_rsp", got, 0);
    xact(10'h040, 2'd0, 3'd1, 0, ge, gq);
    check("midrst_prior", gq, prior);
    for (int i = 0; i < 80; i++) begin
      mode = $urandom_range(0, 9);
      xact(10'($urandom_range(0, 1023)),
           mode < 4 ? 2'($urandom_range(1, 3)) : mode == 9 ? 2'($urandom) : 2'd0,
           mode >= 4 && mode < 9 ? 3'($urandom_range(1, 5)) : mode == 9 ? 3'($urandom) : 3'd0,
           $urandom, ge, gq);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
